// File: rtl/imem_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// imem_dmem_arbiter
//
// Shares one single-port unified memory between the instruction-fetch port
// and the data port of the pipeline. Each access goes through three states:
//   IDLE : pick a requester and latch its command onto mem_*
//   WAIT : issue (mem_en_o for one cycle) and wait for mem_ack_i or watchdog
//   RESP : pulse the owner's ack for one cycle, then return to IDLE
//
// The data port normally wins. A fetch cannot be starved: after MAX_DPRIO
// back-to-back data grants taken while a fetch was waiting, the next grant
// goes to fetch. A hung memory access is completed after TIMEOUT WAIT cycles
// with zero read data, and err_o is raised until reset.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   if_req_i / if_addr_i    fetch request and address (held until ack)
//   if_ack_o / if_rdata_o   fetch completion pulse and read word (held)
//   if_stall_o              fetch request not yet acknowledged
//   dm_req_i, dm_we_i,
//   dm_addr_i, dm_wdata_i   data request, write enable, address, write data
//   dm_ack_o / dm_rdata_o   data completion pulse and read word (held)
//   dm_stall_o              data request not yet acknowledged
//   mem_en_o                one-cycle issue pulse to memory
//   mem_we_o, mem_addr_o,
//   mem_wdata_o             latched command, stable from issue through RESP
//   mem_rdata_i, mem_ack_i  memory read data and completion pulse
//   err_o                   sticky watchdog timeout flag
// ---------------------------------------------------------------------------
module imem_dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_DPRIO = 3,
  parameter int TIMEOUT   = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_stall_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ack_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_stall_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              err_o
);

  localparam int STRK_W = $clog2(MAX_DPRIO + 1);
  // The watchdog counter only needs to reach TIMEOUT-1; the cycle that would
  // make it TIMEOUT is the one that forces completion.
  localparam int TMO_W  = $clog2(TIMEOUT);
  localparam logic [STRK_W-1:0] STRK_MAX = STRK_W'(MAX_DPRIO);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic               owner_dm_q;
  logic [STRK_W-1:0]  streak_q;
  logic [TMO_W-1:0]   tmo_q;

  logic               grant_dm;
  logic               grant_if;
  logic               tmo_hit;

  // Data wins unless a fetch is waiting and the data port has already used
  // its full run of consecutive grants.
  assign grant_dm = dm_req_i && !(if_req_i && (streak_q == STRK_MAX));
  assign grant_if = !grant_dm && if_req_i;
  assign tmo_hit  = !mem_ack_i && (tmo_q == TMO_LAST);

  assign if_ack_o   = (state_q == ST_RESP) && !owner_dm_q;
  assign dm_ack_o   = (state_q == ST_RESP) &&  owner_dm_q;
  assign if_stall_o = if_req_i & ~if_ack_o;
  assign dm_stall_o = dm_req_i & ~dm_ack_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (grant_dm || grant_if)   state_d = ST_WAIT;
      ST_WAIT: if (mem_ack_i || tmo_hit)   state_d = ST_RESP;
      ST_RESP:                             state_d = ST_IDLE;
      default:                             state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_dm_q  <= 1'b0;
      streak_q    <= '0;
      tmo_q       <= '0;
      mem_en_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_rdata_o  <= '0;
      dm_rdata_o  <= '0;
      err_o       <= 1'b0;
    end else begin
      mem_en_o <= 1'b0;
      case (state_q)
        // ---- grant: latch command, start issue ----
        ST_IDLE: begin
          if (grant_dm || grant_if) begin
            mem_en_o   <= 1'b1;
            tmo_q      <= '0;
            owner_dm_q <= grant_dm;
            if (grant_dm) begin
              mem_we_o    <= dm_we_i;
              mem_addr_o  <= dm_addr_i;
              mem_wdata_o <= dm_wdata_i;
              // Only grants that made a fetch wait count toward the streak.
              if (if_req_i) begin
                if (streak_q != STRK_MAX) streak_q <= streak_q + 1'b1;
              end else begin
                streak_q <= '0;
              end
            end else begin
              mem_we_o    <= 1'b0;
              mem_addr_o  <= if_addr_i;
              mem_wdata_o <= '0;
              streak_q    <= '0;
            end
          end
        end
        // ---- wait: memory completion or watchdog ----
        ST_WAIT: begin
          if (mem_ack_i) begin
            if (owner_dm_q) begin
              if (!mem_we_o) dm_rdata_o <= mem_rdata_i;
            end else begin
              if_rdata_o <= mem_rdata_i;
            end
          end else if (tmo_hit) begin
            err_o <= 1'b1;
            if (owner_dm_q) begin
              if (!mem_we_o) dm_rdata_o <= '0;
            end else begin
              if_rdata_o <= '0;
            end
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
module tb_imem_dmem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXD = 3;
  localparam int TMO  = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic          if_ack_o;
  logic [DW-1:0] if_rdata_o;
  logic          if_stall_o;
  logic          dm_req_i;
  logic          dm_we_i;
  logic [AW-1:0] dm_addr_i;
  logic [DW-1:0] dm_wdata_i;
  logic          dm_ack_o;
  logic [DW-1:0] dm_rdata_o;
  logic          dm_stall_o;
  logic          mem_en_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;
  logic          mem_ack_i;
  logic          err_o;

  always #5 clk = ~clk;

  imem_dmem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_DPRIO(MAXD), .TIMEOUT(TMO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o),
    .if_rdata_o(if_rdata_o), .if_stall_o(if_stall_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_ack_o(dm_ack_o), .dm_rdata_o(dm_rdata_o),
    .dm_stall_o(dm_stall_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .err_o(err_o)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_inputs();
    if_req_i = 1'b0; if_addr_i = '0;
    dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0;
    mem_ack_i = 1'b0; mem_rdata_i = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    zero_inputs();
    repeat (2) step();
    rst = 1'b0;
  endtask

  // Directed vectors: in_f = {if_req, dm_req, dm_we, mem_ack}
  // ex_f = {mem_en, if_ack, dm_ack, if_stall, dm_stall, err, check_cmd, mem_we}
  typedef struct {
    logic [3:0]  in_f;
    logic [31:0] ifa, dma, dmwd, mrd;
    logic [7:0]  ex_f;
    logic [31:0] maddr, mwd, ifrd, dmrd;
  } vec_t;

  vec_t vt[15];

  // Reference memory contents for the random run
  bit [31:0] mem_m [bit [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return a ^ 32'h5EED_0000;
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'($urandom_range(0, 7) * 4);
  endfunction

  initial begin
    vt[0]  = '{4'b1000, 32'h10, 32'h0,   32'h0,        32'h0,        8'b0001_0010, 32'h0,   32'h0,        32'h0,        32'h0};
    vt[1]  = '{4'b1001, 32'h10, 32'h0,   32'h0,        32'hDEADBEEF, 8'b1001_0010, 32'h10,  32'h0,        32'h0,        32'h0};
    vt[2]  = '{4'b1000, 32'h10, 32'h0,   32'h0,        32'h0,        8'b0100_0010, 32'h10,  32'h0,        32'hDEADBEEF, 32'h0};
    vt[3]  = '{4'b0001, 32'h0,  32'h0,   32'h0,        32'h11111111, 8'b0000_0000, 32'h0,   32'h0,        32'hDEADBEEF, 32'h0};
    vt[4]  = '{4'b0110, 32'h0,  32'h100, 32'h5A5A5A5A, 32'h0,        8'b0000_1000, 32'h0,   32'h0,        32'hDEADBEEF, 32'h0};
    vt[5]  = '{4'b0110, 32'h0,  32'h100, 32'h5A5A5A5A, 32'h0,        8'b1000_1011, 32'h100, 32'h5A5A5A5A, 32'hDEADBEEF, 32'h0};
    vt[6]  = '{4'b0110, 32'h0,  32'h100, 32'h5A5A5A5A, 32'h0,        8'b0000_1011, 32'h100, 32'h5A5A5A5A, 32'hDEADBEEF, 32'h0};
    vt[7]  = '{4'b0110, 32'h0,  32'h100, 32'h5A5A5A5A, 32'h0,        8'b0000_1011, 32'h100, 32'h5A5A5A5A, 32'hDEADBEEF, 32'h0};
    vt[8]  = '{4'b0111, 32'h0,  32'h100, 32'h5A5A5A5A, 32'hCAFEF00D, 8'b0000_1011, 32'h100, 32'h5A5A5A5A, 32'hDEADBEEF, 32'h0};
    vt[9]  = '{4'b0111, 32'h0,  32'h100, 32'h5A5A5A5A, 32'h22222222, 8'b0010_0011, 32'h100, 32'h5A5A5A5A, 32'hDEADBEEF, 32'h0};
    vt[10] = '{4'b0000, 32'h0,  32'h0,   32'h0,        32'h0,        8'b0000_0000, 32'h0,   32'h0,        32'hDEADBEEF, 32'h0};
    vt[11] = '{4'b0100, 32'h0,  32'h104, 32'h0,        32'h0,        8'b0000_1000, 32'h0,   32'h0,        32'hDEADBEEF, 32'h0};
    vt[12] = '{4'b0101, 32'h0,  32'h104, 32'h0,        32'h12345678, 8'b1000_1010, 32'h104, 32'h0,        32'hDEADBEEF, 32'h0};
    vt[13] = '{4'b0100, 32'h0,  32'h104, 32'h0,        32'h0,        8'b0010_0010, 32'h104, 32'h0,        32'hDEADBEEF, 32'h12345678};
    vt[14] = '{4'b0000, 32'h0,  32'h0,   32'h0,        32'h0,        8'b0000_0000, 32'h0,   32'h0,        32'hDEADBEEF, 32'h12345678};

    // ---------------- directed table: fetch, write, spurious acks, read
    do_reset();
    for (int i = 0; i < 15; i++) begin
      if_req_i    = vt[i].in_f[3];
      dm_req_i    = vt[i].in_f[2];
      dm_we_i     = vt[i].in_f[1];
      mem_ack_i   = vt[i].in_f[0];
      if_addr_i   = vt[i].ifa;
      dm_addr_i   = vt[i].dma;
      dm_wdata_i  = vt[i].dmwd;
      mem_rdata_i = vt[i].mrd;
      #2;
      chk($sformatf("v%0d_mem_en", i),   mem_en_o,   vt[i].ex_f[7]);
      chk($sformatf("v%0d_if_ack", i),   if_ack_o,   vt[i].ex_f[6]);
      chk($sformatf("v%0d_dm_ack", i),   dm_ack_o,   vt[i].ex_f[5]);
      chk($sformatf("v%0d_if_stall", i), if_stall_o, vt[i].ex_f[4]);
      chk($sformatf("v%0d_dm_stall", i), dm_stall_o, vt[i].ex_f[3]);
      chk($sformatf("v%0d_err", i),      err_o,      vt[i].ex_f[2]);
      if (vt[i].ex_f[1]) begin
        chk($sformatf("v%0d_mem_we", i),    mem_we_o,    vt[i].ex_f[0]);
        chk($sformatf("v%0d_mem_addr", i),  mem_addr_o,  vt[i].maddr);
        chk($sformatf("v%0d_mem_wdata", i), mem_wdata_o, vt[i].mwd);
      end
      chk($sformatf("v%0d_if_rdata", i), if_rdata_o, vt[i].ifrd);
      chk($sformatf("v%0d_dm_rdata", i), dm_rdata_o, vt[i].dmrd);
      step();
    end

    // ---------------- contention: both ports held, memory answers at once
    begin
      logic [7:0] got;
      logic [7:0] exp_ord;
      int g;
      exp_ord = 8'b1000_1000;   // bit i set = grant i went to fetch
      got = '0;
      g = 0;
      do_reset();
      if_req_i = 1'b1; if_addr_i = 32'h20;
      dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h200;
      for (int c = 0; c < 100 && g < 8; c++) begin
        mem_ack_i   = mem_en_o;
        mem_rdata_i = 32'(c);
        if (mem_en_o) begin
          got[g] = (mem_addr_o == 32'h20);
          g++;
        end
        #2;
        if (mem_en_o && mem_addr_o == 32'h200)
          chk($sformatf("cont_if_stall_c%0d", c), if_stall_o, 1'b1);
        step();
      end
      chk("cont_ngrants", g, 8);
      for (int i = 0; i < 8; i++)
        chk($sformatf("cont_grant%0d_is_if", i), got[i], exp_ord[i]);
    end

    // ---------------- watchdog timeout on a data read, then sticky err
    begin
      int cnt;
      do_reset();
      dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h300;
      step();                                   // issue cycle
      mem_ack_i = 1'b1; mem_rdata_i = 32'hA1B2C3D4;
      step();                                   // RESP
      mem_ack_i = 1'b0;
      #2;
      chk("tmo_pre_ack", dm_ack_o, 1'b1);
      chk("tmo_pre_rdata", dm_rdata_o, 32'hA1B2C3D4);
      step();                                   // IDLE, new read granted here
      dm_addr_i = 32'h304;
      step();                                   // issue cycle
      #2;
      chk("tmo_issue_en", mem_en_o, 1'b1);
      cnt = 0;
      while (!dm_ack_o && cnt < 200) begin
        chk($sformatf("tmo_err_low_c%0d", cnt), err_o, 1'b0);
        step();
        #2;
        cnt++;
      end
      chk("tmo_latency", cnt, TMO);
      chk("tmo_ack", dm_ack_o, 1'b1);
      chk("tmo_rdata_zero", dm_rdata_o, 32'h0);
      chk("tmo_err_set", err_o, 1'b1);
      step();                                   // IDLE
      dm_req_i = 1'b0;
      if_req_i = 1'b1; if_addr_i = 32'h40;
      step();                                   // issue
      mem_ack_i = 1'b1; mem_rdata_i = 32'h00000077;
      step();                                   // RESP
      mem_ack_i = 1'b0;
      #2;
      chk("tmo_after_if_ack", if_ack_o, 1'b1);
      chk("tmo_after_if_rdata", if_rdata_o, 32'h77);
      chk("tmo_err_sticky", err_o, 1'b1);
      step();
      if_req_i = 1'b0;
      #2;
      chk("tmo_err_sticky2", err_o, 1'b1);
    end

    // ---------------- reset in the middle of WAIT, late acks ignored
    begin
      do_reset();
      if_req_i = 1'b1; if_addr_i = 32'h50;
      step();                                   // issue, no memory response
      step();
      step();
      rst = 1'b1;
      step();                                   // reset takes effect here
      rst = 1'b0;
      if_req_i = 1'b0;
      mem_ack_i = 1'b1; mem_rdata_i = 32'h99;
      #2;
      chk("rst_if_ack", if_ack_o, 1'b0);
      chk("rst_mem_en", mem_en_o, 1'b0);
      chk("rst_mem_addr", mem_addr_o, 32'h0);
      chk("rst_if_rdata", if_rdata_o, 32'h0);
      chk("rst_err", err_o, 1'b0);
      step();
      #2;
      chk("rst_late_if_ack", if_ack_o, 1'b0);
      chk("rst_late_dm_ack", dm_ack_o, 1'b0);
      chk("rst_late_if_rdata", if_rdata_o, 32'h0);
      step();
      mem_ack_i = 1'b0;
      if_req_i = 1'b1; if_addr_i = 32'h54;
      step();                                   // issue
      #2;
      chk("rst_next_en", mem_en_o, 1'b1);
      chk("rst_next_addr", mem_addr_o, 32'h54);
      step();
      mem_ack_i = 1'b1; mem_rdata_i = 32'h55AA;
      step();                                   // RESP
      mem_ack_i = 1'b0;
      #2;
      chk("rst_next_ack", if_ack_o, 1'b1);
      chk("rst_next_rdata", if_rdata_o, 32'h55AA);
      step();
      if_req_i = 1'b0;
    end

    // ---------------- randomized traffic against a transaction-level model
    begin
      bit p_idle, p_ifr, p_dmr, p_dmwe, p_real_ack;
      logic [31:0] p_ifa, p_dma, p_dmwd;
      bit busy, own_dm, own_we, exp_en, exp_ack, gdm, cur_idle;
      bit if_done, dm_done;
      int streak;
      logic [31:0] exp_rd, last_ifrd, last_dmrd;
      bit pend, pwe;
      int lat, cnt;
      logic [31:0] paddr, pwd;

      do_reset();
      p_idle = 1'b1; p_ifr = 1'b0; p_dmr = 1'b0; p_dmwe = 1'b0; p_real_ack = 1'b0;
      p_ifa = '0; p_dma = '0; p_dmwd = '0;
      busy = 1'b0; own_dm = 1'b0; own_we = 1'b0; streak = 0;
      if_done = 1'b0; dm_done = 1'b0;
      exp_rd = '0; last_ifrd = '0; last_dmrd = '0;
      pend = 1'b0; pwe = 1'b0; lat = 0; cnt = 0; paddr = '0; pwd = '0;

      for (int c = 0; c < 3000; c++) begin
        exp_en  = p_idle && (p_ifr || p_dmr);
        exp_ack = p_real_ack;
        chk("rnd_mem_en", mem_en_o, exp_en);
        chk("rnd_if_ack", if_ack_o, exp_ack && !own_dm);
        chk("rnd_dm_ack", dm_ack_o, exp_ack && own_dm);
        if (exp_en) begin
          gdm = p_dmr && !(p_ifr && streak == MAXD);
          own_dm = gdm;
          if (gdm) begin
            chk("rnd_cmd_we_dm", mem_we_o, p_dmwe);
            chk("rnd_cmd_addr_dm", mem_addr_o, p_dma);
            chk("rnd_cmd_wdata_dm", mem_wdata_o, p_dmwd);
            own_we = p_dmwe;
            if (p_ifr) streak = (streak < MAXD) ? streak + 1 : streak;
            else       streak = 0;
          end else begin
            chk("rnd_cmd_we_if", mem_we_o, 1'b0);
            chk("rnd_cmd_addr_if", mem_addr_o, p_ifa);
            own_we = 1'b0;
            streak = 0;
          end
          busy = 1'b1;
        end
        if (exp_ack) begin
          if (own_dm) begin
            if (!own_we) last_dmrd = exp_rd;
          end else begin
            last_ifrd = exp_rd;
          end
        end
        chk("rnd_if_rdata", if_rdata_o, last_ifrd);
        chk("rnd_dm_rdata", dm_rdata_o, last_dmrd);
        chk("rnd_err", err_o, 1'b0);
        cur_idle = !busy;
        if (exp_ack) busy = 1'b0;

        // memory with random latency 0..3, spurious acks while nothing pending
        if (mem_en_o) begin
          pend = 1'b1; lat = $urandom_range(0, 3); cnt = 0;
          pwe = mem_we_o; paddr = mem_addr_o; pwd = mem_wdata_o;
        end
        p_real_ack = 1'b0;
        if (pend && cnt == lat) begin
          mem_ack_i = 1'b1;
          if (pwe) begin
            mem_m[paddr] = pwd;
            mem_rdata_i = $urandom;
          end else begin
            mem_rdata_i = mem_rd(paddr);
          end
          exp_rd = mem_rdata_i;
          pend = 1'b0;
          p_real_ack = 1'b1;
        end else begin
          mem_ack_i = !pend && ($urandom_range(0, 3) == 0);
          mem_rdata_i = $urandom;
          if (pend) cnt++;
        end

        // fetch requester
        if (if_ack_o) begin
          if_done = 1'b1;
        end else if (if_done) begin
          if_done = 1'b0;
          if_req_i = 1'($urandom_range(0, 1));
          if_addr_i = rand_addr();
        end else if (!if_req_i) begin
          if ($urandom_range(0, 2) == 0) begin
            if_req_i = 1'b1;
            if_addr_i = rand_addr();
          end
        end else if (!(busy && !own_dm) && $urandom_range(0, 15) == 0) begin
          if_req_i = 1'b0;
        end

        // data requester
        if (dm_ack_o) begin
          dm_done = 1'b1;
        end else if (dm_done || !dm_req_i) begin
          if ((dm_done && $urandom_range(0, 1) == 1) || (!dm_done && $urandom_range(0, 2) == 0)) begin
            dm_req_i = 1'b1;
            dm_we_i = 1'($urandom_range(0, 1));
            dm_addr_i = rand_addr();
            dm_wdata_i = $urandom;
          end else begin
            dm_req_i = 1'b0;
          end
          dm_done = 1'b0;
        end else if (!(busy && own_dm) && $urandom_range(0, 15) == 0) begin
          dm_req_i = 1'b0;
        end

        #2;
        chk("rnd_if_stall", if_stall_o, if_req_i && !(exp_ack && !own_dm));
        chk("rnd_dm_stall", dm_stall_o, dm_req_i && !(exp_ack && own_dm));

        p_ifr = if_req_i; p_ifa = if_addr_i;
        p_dmr = dm_req_i; p_dmwe = dm_we_i; p_dma = dm_addr_i; p_dmwd = dm_wdata_i;
        p_idle = cur_idle;
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
